// File: rtl/sudoku_pkg.sv
// Shared types, constants and the (group, element) -> cell index mapping
// used by the sudoku board checker.
package sudoku_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int         N_CELLS  = 16;
    localparam int         N_GROUPS = 12;
    localparam int         SCAN_LEN = N_GROUPS * 4;
    localparam int         IDX_W    = $clog2(N_CELLS);
    localparam logic [3:0] NO_GROUP = 4'hF;

    // Tag that travels alongside a read until its data comes back.
    typedef struct packed {
        logic       valid;
        logic [3:0] group;
        logic [1:0] elem;
    } tag_t;

    // Groups 0..3 are rows, 4..7 columns, 8..11 2x2 boxes; low two group
    // bits select which row/column/box.
    function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] group,
                                                 input logic [1:0] elem);
        logic [1:0] row;
        logic [1:0] col;
        if (group < 4'd4) begin
            row = group[1:0];
            col = elem;
        end else if (group < 4'd8) begin
            row = elem;
            col = group[1:0];
        end else begin
            row = {group[1], elem[1]};
            col = {group[0], elem[0]};
        end
        return {row, col};
    endfunction

endpackage

// File: rtl/sudoku_group_acc.sv
// Per-group duplicate/fill tracking plus the running board-level results.
// The *_nxt outputs already include the element presented this cycle.
module sudoku_group_acc
    import sudoku_pkg::*;
(
    input  logic       clk,
    input  logic       restart,
    input  logic       clear,
    input  logic       valid,
    input  logic [3:0] group,
    input  logic [1:0] elem,
    input  logic       fill,
    input  logic [1:0] value,
    output logic [3:0] conflict_cnt_nxt,
    output logic [3:0] bad_group_nxt,
    output logic       full_nxt
);

    logic [3:0] seen, seen_nxt;
    logic       dup, dup_nxt;
    logic       incomplete, inc_nxt;
    logic [3:0] conflict_cnt;
    logic [3:0] bad_group;
    logic       full;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        seen_nxt         = seen;
        dup_nxt          = dup;
        inc_nxt          = incomplete;
        conflict_cnt_nxt = conflict_cnt;
        bad_group_nxt    = bad_group;
        full_nxt         = full;
        if (valid) begin
            if (elem == 2'd0) begin
                seen_nxt = '0;
                dup_nxt  = 1'b0;
                inc_nxt  = 1'b0;
            end
            if (fill) begin
                if (seen_nxt[value]) dup_nxt = 1'b1;
                else                 seen_nxt[value] = 1'b1;
            end else begin
                inc_nxt = 1'b1;
            end
            if (elem == 2'd3) begin
                if (dup_nxt) conflict_cnt_nxt = conflict_cnt + 4'd1;
                if ((dup_nxt || inc_nxt) && bad_group == NO_GROUP) bad_group_nxt = group;
                if (inc_nxt) full_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (restart || clear) begin
            seen         <= '0;
            dup          <= 1'b0;
            incomplete   <= 1'b0;
            conflict_cnt <= '0;
            bad_group    <= NO_GROUP;
            full         <= 1'b1;
        end else begin
            seen         <= seen_nxt;
            dup          <= dup_nxt;
            incomplete   <= inc_nxt;
            conflict_cnt <= conflict_cnt_nxt;
            bad_group    <= bad_group_nxt;
            full         <= full_nxt;
        end
    end

endmodule

// File: rtl/sudoku_board_checker.sv
// Board checker: scans all 16 cells three times (rows, columns, boxes) through
// the board read port and reports fill, conflict and solved status.
module sudoku_board_checker
    import sudoku_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       in_clka,
    input  logic       in_restart,
    input  logic       in_start,
    input  logic [1:0] in_rdata,
    input  logic       in_rfill,
    output logic [3:0] out_ridx,
    output logic       out_rd_en,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_solved,
    output logic       out_full,
    output logic [3:0] out_conflict_cnt,
    output logic [3:0] out_bad_group,
    output logic [1:0] out_state
);

    localparam logic [5:0] LAST_READ  = 6'(SCAN_LEN - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    state_t     state;
    logic [5:0] n;
    logic [5:0] n_inc;
    logic [1:0] drain_cnt;
    logic       accept;
    tag_t       pipe [RD_LAT];
    logic [3:0] acc_cnt;
    logic [3:0] acc_bad;
    logic       acc_full;

    assign accept    = (state == ST_IDLE) && in_start;
    assign n_inc     = n + 6'd1;
    assign out_state = state;

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            state            <= ST_IDLE;
            n                <= '0;
            drain_cnt        <= '0;
            out_ridx         <= '0;
            out_rd_en        <= 1'b0;
            out_busy         <= 1'b0;
            out_done         <= 1'b0;
            out_solved       <= 1'b0;
            out_full         <= 1'b0;
            out_conflict_cnt <= '0;
            out_bad_group    <= NO_GROUP;
        end else begin
            out_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (in_start) begin
                        state            <= ST_SCAN;
                        n                <= '0;
                        out_ridx         <= cell_idx(4'd0, 2'd0);
                        out_rd_en        <= 1'b1;
                        out_busy         <= 1'b1;
                        out_solved       <= 1'b0;
                        out_full         <= 1'b0;
                        out_conflict_cnt <= '0;
                        out_bad_group    <= NO_GROUP;
                    end
                end
                ST_SCAN: begin
                    if (n == LAST_READ) begin
                        state     <= ST_DRAIN;
                        out_rd_en <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        n        <= n_inc;
                        out_ridx <= cell_idx(n_inc[5:2], n_inc[1:0]);
                    end
                end
                ST_DRAIN: begin
                    // The last read's data is in flight this cycle; take the
                    // accumulator's look-ahead so it is included.
                    if (drain_cnt == DRAIN_LAST) begin
                        state            <= ST_DONE;
                        out_busy         <= 1'b0;
                        out_done         <= 1'b1;
                        out_full         <= acc_full;
                        out_solved       <= acc_full && (acc_cnt == 4'd0);
                        out_conflict_cnt <= acc_cnt;
                        out_bad_group    <= acc_bad;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
            endcase
        end
    end

    // Group/element tag delayed to line up with the returning read data.
    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            // NOTE: only the valid flags are reset; the tag fields are qualified by them and need no reset.
            for (int i = 0; i < RD_LAT; i++) pipe[i].valid <= 1'b0;
        end else begin
            pipe[0] <= '{valid: out_rd_en, group: n[5:2], elem: n[1:0]};
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    sudoku_group_acc u_acc (
        .clk              (in_clka),
        .restart          (in_restart),
        .clear            (accept),
        .valid            (pipe[RD_LAT-1].valid),
        .group            (pipe[RD_LAT-1].group),
        .elem             (pipe[RD_LAT-1].elem),
        .fill             (in_rfill),
        .value            (in_rdata),
        .conflict_cnt_nxt (acc_cnt),
        .bad_group_nxt    (acc_bad),
        .full_nxt         (acc_full)
    );

endmodule

// File: tb/tb_sudoku_board_checker.sv
// Bench for sudoku_board_checker: directed boards plus random boards on two
// instances (RD_LAT = 1 and 2), checked against a row/column/box model.
module tb_sudoku_board_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      start_s   = '0;
    logic [1:0]      restart_s = '1;
    logic [1:0][1:0] rdata_s   = '0;
    logic [1:0]      rfill_s   = '0;
    logic [1:0][3:0] ridx_s, cnt_s, bad_s;
    logic [1:0][1:0] state_s;
    logic [1:0]      rd_en_s, busy_s, done_s, solved_s, full_s;

    sudoku_board_checker #(.RD_LAT(1)) dut1 (
        .in_clka(clk), .in_restart(restart_s[0]), .in_start(start_s[0]),
        .in_rdata(rdata_s[0]), .in_rfill(rfill_s[0]),
        .out_ridx(ridx_s[0]), .out_rd_en(rd_en_s[0]), .out_busy(busy_s[0]),
        .out_done(done_s[0]), .out_solved(solved_s[0]), .out_full(full_s[0]),
        .out_conflict_cnt(cnt_s[0]), .out_bad_group(bad_s[0]), .out_state(state_s[0])
    );

    sudoku_board_checker #(.RD_LAT(2)) dut2 (
        .in_clka(clk), .in_restart(restart_s[1]), .in_start(start_s[1]),
        .in_rdata(rdata_s[1]), .in_rfill(rfill_s[1]),
        .out_ridx(ridx_s[1]), .out_rd_en(rd_en_s[1]), .out_busy(busy_s[1]),
        .out_done(done_s[1]), .out_solved(solved_s[1]), .out_full(full_s[1]),
        .out_conflict_cnt(cnt_s[1]), .out_bad_group(bad_s[1]), .out_state(state_s[1])
    );

    // Instance under test: 0 -> RD_LAT 1, 1 -> RD_LAT 2.
    logic       sel = 1'b0;
    logic [3:0] ridx_o, cnt_o, bad_o;
    logic [1:0] state_o;
    logic       rd_en_o, busy_o, done_o, solved_o, full_o;
    assign ridx_o   = ridx_s[sel];
    assign cnt_o    = cnt_s[sel];
    assign bad_o    = bad_s[sel];
    assign state_o  = state_s[sel];
    assign rd_en_o  = rd_en_s[sel];
    assign busy_o   = busy_s[sel];
    assign done_o   = done_s[sel];
    assign solved_o = solved_s[sel];
    assign full_o   = full_s[sel];

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] bv [4][4];
    logic       bf [4][4];
    int base [4][4] = '{'{0, 1, 2, 3}, '{2, 3, 0, 1}, '{1, 0, 3, 2}, '{3, 2, 1, 0}};
    int hist [2][3];
    int rd_log [$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Board memory: data for the read seen RD_LAT cycles ago.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            hist[i][2] = hist[i][1];
            hist[i][1] = hist[i][0];
            hist[i][0] = int'(ridx_s[i]);
        end
        rdata_s[0] = bv[hist[0][1] / 4][hist[0][1] % 4];
        rfill_s[0] = bf[hist[0][1] / 4][hist[0][1] % 4];
        rdata_s[1] = bv[hist[1][2] / 4][hist[1][2] % 4];
        rfill_s[1] = bf[hist[1][2] / 4][hist[1][2] % 4];
    end

    function automatic void cell_of(input int g, input int k, output int r, output int c);
        if (g < 4) begin
            r = g; c = k;
        end else if (g < 8) begin
            r = k; c = g - 4;
        end else begin
            r = 2 * ((g - 8) / 2) + k / 2;
            c = 2 * ((g - 8) % 2) + k % 2;
        end
    endfunction

    // Reference: count value occurrences per group, flag holes and repeats.
    function automatic void model(output int e_cnt, output int e_bad, output int e_full);
        e_cnt = 0; e_bad = 15; e_full = 1;
        for (int g = 0; g < 12; g++) begin
            int  occ [4];
            bit  hole, dup;
            int  r, c;
            hole = 1'b0; dup = 1'b0;
            for (int v = 0; v < 4; v++) occ[v] = 0;
            for (int k = 0; k < 4; k++) begin
                cell_of(g, k, r, c);
                if (!bf[r][c]) hole = 1'b1;
                else           occ[int'(bv[r][c])]++;
            end
            for (int v = 0; v < 4; v++) if (occ[v] > 1) dup = 1'b1;
            if (dup) e_cnt++;
            if ((dup || hole) && e_bad == 15) e_bad = g;
            if (hole) e_full = 0;
        end
    endfunction

    task automatic load_base();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                bv[r][c] = 2'(base[r][c]);
                bf[r][c] = 1'b1;
            end
    endtask

    task automatic random_board();
        int x, tr, r, c;
        x  = int'($urandom_range(0, 3));
        tr = int'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                r = tr ? j : i;
                c = tr ? i : j;
                bv[r][c] = 2'(base[i][j] ^ x);
                bf[r][c] = 1'b1;
            end
        if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < 16; i++) begin
                bv[i / 4][i % 4] = 2'($urandom_range(0, 3));
                bf[i / 4][i % 4] = ($urandom_range(0, 9) != 0);
            end
        end else begin
            repeat ($urandom_range(0, 3)) begin
                r = int'($urandom_range(0, 15));
                bv[r / 4][r % 4] = 2'($urandom_range(0, 3));
            end
            repeat ($urandom_range(0, 2)) begin
                r = int'($urandom_range(0, 15));
                bf[r / 4][r % 4] = 1'b0;
            end
        end
    endtask

    // One full check; poke adds stray starts during SCAN and DONE.
    task automatic run_scan(input string tag, input bit poke);
        int cyc, done_cyc, n_done, n_bad_idx, rd_n, r, c, lat;
        int e_cnt, e_bad, e_full;
        lat = sel ? 2 : 1;
        model(e_cnt, e_bad, e_full);
        rd_log.delete();
        @(negedge clk); start_s[sel] = 1'b1;
        @(negedge clk); start_s[sel] = 1'b0;
        cyc = 1; done_cyc = 0; n_done = 0; n_bad_idx = 0; rd_n = 0;
        while (cyc <= 70) begin
            if (rd_en_o) begin
                rd_log.push_back(int'(ridx_o));
                cell_of(rd_n / 4, rd_n % 4, r, c);
                if (int'(ridx_o) != 4 * r + c) n_bad_idx++;
                rd_n++;
            end
            if (cyc == 10) begin
                check($sformatf("%s:busy_mid", tag), busy_o, 1);
                check($sformatf("%s:state_mid", tag), state_o, 1);
                check($sformatf("%s:bad_while_busy", tag), bad_o, 15);
            end
            if (done_o) begin
                n_done++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            start_s[sel] = poke && (cyc == 10 || done_o);
            @(negedge clk);
            cyc++;
        end
        start_s[sel] = 1'b0;
        check($sformatf("%s:done_cycle", tag), done_cyc, 49 + lat);
        check($sformatf("%s:done_count", tag), n_done, 1);
        check($sformatf("%s:read_count", tag), rd_n, 48);
        check($sformatf("%s:ridx_errors", tag), n_bad_idx, 0);
        check($sformatf("%s:busy_end", tag), busy_o, 0);
        check($sformatf("%s:full", tag), full_o, e_full);
        check($sformatf("%s:solved", tag), solved_o, int'(e_full == 1 && e_cnt == 0));
        check($sformatf("%s:conflict_cnt", tag), cnt_o, e_cnt);
        check($sformatf("%s:bad_group", tag), bad_o, e_bad);
    endtask

    task automatic check_results(input string tag, input int cnt, input int bad,
                                 input int full, input int solved);
        check($sformatf("%s:plan_cnt", tag), cnt_o, cnt);
        check($sformatf("%s:plan_bad", tag), bad_o, bad);
        check($sformatf("%s:plan_full", tag), full_o, full);
        check($sformatf("%s:plan_solved", tag), solved_o, solved);
    endtask

    task automatic restart_mid(input string tag);
        int n_done;
        @(negedge clk); start_s[sel] = 1'b1;
        @(negedge clk); start_s[sel] = 1'b0;
        repeat (19) @(negedge clk);
        restart_s[sel] = 1'b1;
        @(negedge clk);
        restart_s[sel] = 1'b0;
        check($sformatf("%s:state", tag), state_o, 0);
        check($sformatf("%s:busy", tag), busy_o, 0);
        check($sformatf("%s:bad", tag), bad_o, 15);
        check($sformatf("%s:cnt", tag), cnt_o, 0);
        check($sformatf("%s:full", tag), full_o, 0);
        n_done = 0;
        repeat (60) begin
            if (done_o) n_done++;
            @(negedge clk);
        end
        check($sformatf("%s:no_done", tag), n_done, 0);
    endtask

    initial begin
        int box0 [4] = '{0, 1, 4, 5};
        load_base();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check($sformatf("reset%0d:state", s), state_o, 0);
            check($sformatf("reset%0d:bad", s), bad_o, 15);
            check($sformatf("reset%0d:busy", s), busy_o, 0);
            check($sformatf("reset%0d:done", s), done_o, 0);
            check($sformatf("reset%0d:solved", s), solved_o, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        restart_s = '0;
        start_s[0] = 1'b0;
        check("reset_wins:state", state_o, 0);
        check("reset_wins:busy", busy_o, 0);

        load_base();
        run_scan("solved", 1'b0);
        check_results("solved", 0, 15, 1, 1);
        for (int i = 0; i < 5; i++) check($sformatf("solved:ridx%0d", i), rd_log[i], i);
        for (int i = 0; i < 4; i++) check($sformatf("solved:box0_%0d", i), rd_log[32 + i], box0[i]);

        load_base(); bv[2][1] = 2'd1;
        run_scan("dup9", 1'b0);
        check_results("dup9", 3, 2, 1, 0);

        load_base(); bf[3][3] = 1'b0; bv[3][3] = 2'd3;
        run_scan("hole15", 1'b0);
        check_results("hole15", 0, 3, 0, 0);

        for (int i = 0; i < 16; i++) begin
            bv[i / 4][i % 4] = 2'd0;
            bf[i / 4][i % 4] = 1'b0;
        end
        run_scan("empty", 1'b0);
        check_results("empty", 0, 0, 0, 0);

        load_base();
        run_scan("poke", 1'b1);
        bv[0][0] = 2'd3;
        run_scan("after_poke", 1'b0);

        restart_mid("rst20");

        sel = 1'b1;
        load_base();
        run_scan("lat2", 1'b0);
        check_results("lat2", 0, 15, 1, 1);

        for (int t = 0; t < 12; t++) begin
            sel = 1'(t % 2);
            random_board();
            run_scan($sformatf("rand%0d", t), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sudoku_board_checker.md
Name: sudoku_board_checker

Overview:
- Sequencer that scans the 4x4 Sudoku board register file through its read port and checks all 12 groups: 4 rows, 4 columns and 4 2x2 boxes.
- Sits between the main game FSM (which pulses start on enter) and the board datapath.
- Reports board-full, duplicate-value conflicts, first failing group and solved status.
- Latency is fixed; there is no early exit.

Parameters:
RD_LAT, 1, board read latency in cycles from out_rd_en/out_ridx to valid in_rdata/in_rfill; legal values are 1 or 2.

Ports:
in_clka  input  1  system clock; all logic on rising edge
in_restart  input  1  synchronous active-high reset
in_start  input  1  request a full board check; sampled only in IDLE
in_rdata  input  2  value of the addressed cell, valid RD_LAT cycles after the read
in_rfill  input  1  filled flag of the addressed cell, same timing as in_rdata
out_ridx  output  4  cell index = 4*row + col
out_rd_en  output  1  read strobe
out_busy  output  1  high in SCAN and DRAIN
out_done  output  1  one-cycle pulse when results become valid
out_solved  output  1  board full and no conflicts
out_full  output  1  all 16 cells filled
out_conflict_cnt  output  4  number of groups containing a duplicate value (0..12)
out_bad_group  output  4  lowest group index that has a duplicate or an unfilled cell; 4'hF if none
out_state  output  2  FSM state, for debug

Behaviour:
- Clock and reset: one clock, in_clka; reset in_restart is synchronous, active-high.
- Reset values:
  - FSM goes to IDLE.
  - All outputs are 0, except out_bad_group = 4'hF.
  - Reset wins over a simultaneous in_start.
  - Reset mid-scan aborts the scan and clears all results.
- States (out_state): IDLE = 0, SCAN = 1, DRAIN = 2, DONE = 3.
- IDLE -> SCAN when in_start = 1. This clears the result accumulators and sets the read counter n = 0.
- SCAN runs for 48 cycles with out_rd_en = 1, issuing read n = 0..47.
  - Group g = n[5:2], element e = n[1:0].
  - Rows, g = 0..3: row = g, col = e.
  - Columns, g = 4..7: col = g-4, row = e.
  - Boxes, g = 8..11: b = g-8; row = 2*b[1] + e[1], col = 2*b[0] + e[0].
  - After read 47, go to DRAIN.
- DRAIN lasts RD_LAT cycles with out_rd_en = 0. It then goes to DONE.
- DONE lasts one cycle with out_done = 1, then returns to IDLE.
- Results are latched at DONE entry and held until the next accepted start or reset. Results are 0 / 4'hF while busy.
- Latency: start sampled at edge 0, out_done high during cycle 49 + RD_LAT.
- Data path: pipeline (g, e) by RD_LAT stages alongside the read.
- Per-group accumulation:
  - Keep a 4-bit seen mask, a dup flag and an incomplete flag per group.
  - On valid data with in_rfill = 1: if seen[in_rdata] is already set, set dup; otherwise set seen[in_rdata].
  - With in_rfill = 0: set incomplete and ignore in_rdata.
  - Clear the mask at e = 0.
- At e = 3 of each group:
  - If dup, increment the conflict count.
  - If dup or incomplete, and bad_group is still 4'hF, capture g.
  - If incomplete, clear the full flag.
- Result rules:
  - out_full = no group incomplete.
  - out_solved = out_full && out_conflict_cnt == 0.
  - The conflict count saturates naturally at 12; 4 bits are sufficient.
- in_start while busy or in DONE is ignored; it is not queued.
- in_rdata/in_rfill outside valid slots are don't-care.

Decomposition:
- Shared package sudoku_pkg holds:
  - state encodings;
  - constants N_CELLS = 16, N_GROUPS = 12, SCAN_LEN = 48, NO_GROUP = 4'hF;
  - a cell-index function (group, element) -> idx.
- Sub-module sudoku_group_acc: seen mask, dup/incomplete flags and end-of-group reporting. The top module holds the FSM, counter and pipeline.

Test Plan:
- Solved board, rows 0123/2301/1032/3210, all filled, RD_LAT = 1, pulse start:
  - out_done pulse 50 cycles after the start edge;
  - out_solved = 1, out_full = 1, out_conflict_cnt = 0, out_bad_group = F;
  - out_ridx sequence begins 0,1,2,3,4 and the box-0 reads are 0,1,4,5.
- Same board but cell 9 set to 1:
  - out_conflict_cnt = 3 (groups 2, 5, 10);
  - out_bad_group = 2, out_full = 1, out_solved = 0.
- Solved board with cell 15 unfilled (in_rfill = 0, rdata = 3):
  - out_full = 0, out_conflict_cnt = 0, out_bad_group = 3, out_solved = 0.
- All cells unfilled, value 0:
  - out_full = 0, out_conflict_cnt = 0, out_bad_group = 0.
- Extra in_start pulses during SCAN and DONE:
  - ignored; exactly one out_done; then a new start is accepted from IDLE.
- in_restart at SCAN cycle 20:
  - next cycle out_state = 0, out_busy = 0, out_bad_group = F, no out_done.
  - Rerun with RD_LAT = 2: out_done at cycle 51 and results match the first scenario.
